// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - fetch stage state encodings and instruction field positions
//
// Contents:
//   fetch_state_t   : FS_IDLE, FS_REQ, FS_HOLD, FS_DISCARD (2-bit state register)
//   INSTR_W         : instruction word width
//   INSTR_*_HI/LO   : bit positions of the op / ra / rb fields in an instruction word
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_REQ     = 2'd1,
        FS_HOLD    = 2'd2,
        FS_DISCARD = 2'd3
    } fetch_state_t;

    localparam int INSTR_W     = 8;
    localparam int INSTR_OP_HI = 7;
    localparam int INSTR_OP_LO = 4;
    localparam int INSTR_RA_HI = 3;
    localparam int INSTR_RA_LO = 2;
    localparam int INSTR_RB_HI = 1;
    localparam int INSTR_RB_LO = 0;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, instruction register, imem req/ack and decode handshake
//
// Parameters:
//   OP        opcode width presented on id_op
//   ADDR_W    instruction address width
//   RESET_PC  PC loaded on reset
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req, imem_addr (out)        fetch request, held until imem_ack
//   imem_ack, imem_rdata (in)        fetch completion and instruction word
//   redirect_valid, redirect_addr    branch/jump target load, highest priority
//   id_valid (out), id_ready (in)    decode handshake
//   id_op, id_ra, id_rb, id_pc (out) registered instruction fields and fetch address
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int OP           = 4,
    parameter int ADDR_W       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [OP-1:0]      id_op,
    output logic [1:0]         id_ra,
    output logic [1:0]         id_rb,
    output logic [ADDR_W-1:0]  id_pc
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    // Address of the request that could not be withdrawn after a redirect;
    // pc already points at the redirect target while this is still on the bus.
    logic [ADDR_W-1:0]  disc_addr;
    logic [INSTR_W-1:0] ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FS_IDLE;
            pc        <= RESET_PC_A;
            disc_addr <= RESET_PC_A;
            ir        <= '0;
            id_pc     <= '0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (redirect_valid) begin
                        pc <= redirect_addr;
                    end
                    state <= FS_REQ;
                end
                FS_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_addr;
                        if (imem_ack) begin
                            state <= FS_REQ;
                        end else begin
                            disc_addr <= pc;
                            state     <= FS_DISCARD;
                        end
                    end else if (imem_ack) begin
                        ir    <= imem_rdata;
                        id_pc <= pc;
                        pc    <= pc + ADDR_W'(1);
                        state <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    // A redirect with id_ready=1 still completes the transfer;
                    // either way the held instruction is released.
                    if (redirect_valid) begin
                        pc    <= redirect_addr;
                        state <= FS_REQ;
                    end else if (id_ready) begin
                        state <= FS_REQ;
                    end
                end
                FS_DISCARD: begin
                    if (redirect_valid) begin
                        pc <= redirect_addr;
                    end else if (imem_ack) begin
                        state <= FS_REQ;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    assign imem_req  = (state == FS_REQ) || (state == FS_DISCARD);
    assign imem_addr = (state == FS_DISCARD) ? disc_addr : pc;
    assign id_valid  = (state == FS_HOLD);
    assign id_op     = OP'(ir[INSTR_OP_HI:INSTR_OP_LO]);
    assign id_ra     = ir[INSTR_RA_HI:INSTR_RA_LO];
    assign id_rb     = ir[INSTR_RB_HI:INSTR_RB_LO];

endmodule
